// File: rtl/ej32_rs_arb.sv
// Return-stack arbiter/pointer manager: shares one BRAM between core (push/pop/move/peek) and debug (random rd/wr).
// Latency: grants are same-cycle combinational; read data (core_q/dbg_q) returns exactly 1 cycle after grant.
// Backpressure: requesters hold req+payload until gnt; core has priority, debug is forced through after STARVE-1 waits.
module ej32_rs_arb #(
    parameter int DSZ      = 32,
    parameter int RS_DEPTH = 32,
    parameter int PSZ      = 5,
    parameter int STARVE   = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           core_req,
    input  logic [1:0]     core_op,
    input  logic [PSZ-1:0] core_ofs,
    input  logic [DSZ-1:0] core_d,
    output logic           core_gnt,
    output logic [DSZ-1:0] core_q,
    output logic           core_qv,
    input  logic           dbg_req,
    input  logic           dbg_we,
    input  logic [PSZ-1:0] dbg_addr,
    input  logic [DSZ-1:0] dbg_d,
    output logic           dbg_gnt,
    output logic [DSZ-1:0] dbg_q,
    output logic           dbg_qv,
    output logic           mem_wen,
    output logic [PSZ-1:0] mem_waddr,
    output logic [DSZ-1:0] mem_wdata,
    output logic           mem_ren,
    output logic [PSZ-1:0] mem_raddr,
    input  logic [DSZ-1:0] mem_rdata,
    output logic [PSZ-1:0] rp,
    output logic [PSZ:0]   depth,
    output logic           ovf,
    output logic           unf,
    input  logic           err_clr
);

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_MOVE = 2'd2;
    localparam logic [1:0] OP_PEEK = 2'd3;

    localparam int SCW = $clog2(STARVE) + 1;
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE - 1);
    localparam logic [PSZ:0]   DEPTH_FULL = (PSZ+1)'(RS_DEPTH);

    logic [SCW-1:0] starve_cnt;
    logic           force_dbg;
    logic           core_take;
    logic           dbg_take;
    logic           full;
    logic           empty;
    logic           core_zero;

    logic           wen_c;
    logic [PSZ-1:0] waddr_c;
    logic [DSZ-1:0] wdata_c;
    logic           ren_c;
    logic [PSZ-1:0] raddr_c;
    logic [PSZ-1:0] rp_nxt;
    logic [PSZ:0]   depth_nxt;
    logic           ovf_set;
    logic           unf_set;
    logic           core_rd;
    logic           core_zero_nxt;
    logic           dbg_rd;

    assign full  = (depth == DEPTH_FULL);
    assign empty = (depth == '0);

    // Debug is forced through once it has waited STARVE-1 cycles; flush blocks both requesters.
    assign force_dbg = dbg_req && (starve_cnt == STARVE_MAX);
    assign core_take = !flush && core_req && !force_dbg;
    assign dbg_take  = !flush && dbg_req && (!core_req || force_dbg);

    // Handshake and BRAM strobes are held quiet while reset is asserted, even if requests are up.
    assign core_gnt  = rst && core_take;
    assign dbg_gnt   = rst && dbg_take;
    assign mem_wen   = rst && wen_c;
    assign mem_ren   = rst && ren_c;
    assign mem_waddr = rst ? waddr_c : '0;
    assign mem_wdata = rst ? wdata_c : '0;
    assign mem_raddr = rst ? raddr_c : '0;

    // Underflowed POP still pulses core_qv but returns zero instead of stale BRAM data.
    assign core_q = (core_qv && !core_zero) ? mem_rdata : '0;
    assign dbg_q  = dbg_qv ? mem_rdata : '0;

    // Decode the granted request into BRAM strobes, pointer/depth updates and error sets.
    always_comb begin
        wen_c         = 1'b0;
        waddr_c       = '0;
        wdata_c       = '0;
        ren_c         = 1'b0;
        raddr_c       = '0;
        rp_nxt        = rp;
        depth_nxt     = depth;
        ovf_set       = 1'b0;
        unf_set       = 1'b0;
        core_rd       = 1'b0;
        core_zero_nxt = 1'b0;
        dbg_rd        = 1'b0;
        if (core_take) begin
            case (core_op)
                OP_PUSH: begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        wen_c     = 1'b1;
                        waddr_c   = rp + PSZ'(1);
                        wdata_c   = core_d;
                        rp_nxt    = rp + PSZ'(1);
                        depth_nxt = depth + (PSZ+1)'(1);
                    end
                end
                OP_POP: begin
                    core_rd = 1'b1;
                    if (empty) begin
                        unf_set       = 1'b1;
                        core_zero_nxt = 1'b1;
                    end else begin
                        ren_c     = 1'b1;
                        raddr_c   = rp;
                        rp_nxt    = rp - PSZ'(1);
                        depth_nxt = depth - (PSZ+1)'(1);
                    end
                end
                OP_MOVE: begin
                    wen_c   = 1'b1;
                    waddr_c = rp;
                    wdata_c = core_d;
                end
                OP_PEEK: begin
                    core_rd = 1'b1;
                    ren_c   = 1'b1;
                    raddr_c = rp - core_ofs;
                end
                default: ;
            endcase
        end else if (dbg_take) begin
            if (dbg_we) begin
                wen_c   = 1'b1;
                waddr_c = dbg_addr;
                wdata_c = dbg_d;
            end else begin
                ren_c   = 1'b1;
                raddr_c = dbg_addr;
                dbg_rd  = 1'b1;
            end
        end
        if (flush) begin
            rp_nxt    = '0;
            depth_nxt = '0;
        end
    end

    // Stack pointer and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rp    <= '0;
            depth <= '0;
        end else begin
            rp    <= rp_nxt;
            depth <= depth_nxt;
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= ovf_set | (ovf & ~err_clr);
            unf <= unf_set | (unf & ~err_clr);
        end
    end

    // Read-return tracking: one-cycle valid pulses aligned with the BRAM read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_qv   <= 1'b0;
            core_zero <= 1'b0;
            dbg_qv    <= 1'b0;
        end else begin
            core_qv   <= core_rd;
            core_zero <= core_zero_nxt;
            dbg_qv    <= dbg_rd;
        end
    end

    // Debug starvation counter: counts waiting cycles, saturates at the forcing threshold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!dbg_req || dbg_take) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + SCW'(1);
        end
    end

endmodule

// File: tb/tb_ej32_rs_arb.sv
// Directed bench for ej32_rs_arb with a behavioural 1-cycle-latency BRAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Every comparison funnels through check(); a single summary line closes the run.
module tb_ej32_rs_arb;

    localparam logic [1:0] PUSH = 2'd0;
    localparam logic [1:0] POP  = 2'd1;
    localparam logic [1:0] MOVE = 2'd2;
    localparam logic [1:0] PEEK = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        core_req;
    logic [1:0]  core_op;
    logic [4:0]  core_ofs;
    logic [31:0] core_d;
    logic        core_gnt;
    logic [31:0] core_q;
    logic        core_qv;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_d;
    logic        dbg_gnt;
    logic [31:0] dbg_q;
    logic        dbg_qv;
    logic        mem_wen;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_ren;
    logic [4:0]  mem_raddr;
    logic [31:0] mem_rdata;
    logic [4:0]  rp;
    logic [5:0]  depth;
    logic        ovf;
    logic        unf;
    logic        err_clr;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] bram [32];

    logic        g_gnt, g_wen, g_ren, r_qv;
    logic [4:0]  g_waddr, g_raddr;
    logic [31:0] r_q;
    logic        d_gnt, d_qv;
    logic [31:0] d_q;

    always #5 clk = ~clk;

    ej32_rs_arb dut (
        .clk(clk), .rst(rst), .flush(flush),
        .core_req(core_req), .core_op(core_op), .core_ofs(core_ofs), .core_d(core_d),
        .core_gnt(core_gnt), .core_q(core_q), .core_qv(core_qv),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_d(dbg_d),
        .dbg_gnt(dbg_gnt), .dbg_q(dbg_q), .dbg_qv(dbg_qv),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .rp(rp), .depth(depth), .ovf(ovf), .unf(unf), .err_clr(err_clr)
    );

    // Behavioural dual-port BRAM: synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_wen) bram[mem_waddr] <= mem_wdata;
        if (mem_ren) mem_rdata <= bram[mem_raddr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One core request from posedge+1: samples grant-cycle strobes, then the result cycle.
    task automatic core_cycle(input logic [1:0] op, input logic [4:0] ofs, input logic [31:0] d);
        core_req = 1'b1; core_op = op; core_ofs = ofs; core_d = d;
        @(negedge clk);
        g_gnt = core_gnt; g_wen = mem_wen; g_waddr = mem_waddr;
        g_ren = mem_ren;  g_raddr = mem_raddr;
        @(posedge clk); #1;
        core_req = 1'b0;
        @(negedge clk);
        r_qv = core_qv; r_q = core_q;
        @(posedge clk); #1;
    endtask

    // One uncontended debug request.
    task automatic dbg_cycle(input logic we, input logic [4:0] addr, input logic [31:0] d);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_d = d;
        @(negedge clk);
        d_gnt = dbg_gnt;
        @(posedge clk); #1;
        dbg_req = 1'b0;
        @(negedge clk);
        d_qv = dbg_qv; d_q = dbg_q;
        @(posedge clk); #1;
    endtask

    initial begin
        int gcyc;
        int core_miss;
        int wr_cnt;
        logic cg_at;
        for (int i = 0; i < 32; i++) bram[i] = 32'h0;
        mem_rdata = 32'h0;
        rst = 1'b0; flush = 1'b0; err_clr = 1'b0;
        core_req = 1'b1; core_op = POP; core_ofs = 5'd0; core_d = 32'h0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_d = 32'hDEAD;

        // Reset state with requests up: nothing granted, nothing touches the BRAM.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_core_gnt", core_gnt, 0);
        check("rst_dbg_gnt", dbg_gnt, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_mem_ren", mem_ren, 0);
        check("rst_core_qv", core_qv, 0);
        check("rst_rp", rp, 0);
        check("rst_depth", depth, 0);
        check("rst_flags", {ovf, unf}, 0);
        @(posedge clk); #1;
        core_req = 1'b0; dbg_req = 1'b0; rst = 1'b1;

        // PUSH 0xA, 0xB, 0xC into slots 1..3.
        core_cycle(PUSH, 5'd0, 32'hA);
        check("push1_gnt", g_gnt, 1); check("push1_waddr", g_waddr, 1);
        core_cycle(PUSH, 5'd0, 32'hB);
        check("push2_waddr", g_waddr, 2);
        core_cycle(PUSH, 5'd0, 32'hC);
        check("push3_waddr", g_waddr, 3); check("push3_wen", g_wen, 1);
        check("push_rp", rp, 3);
        check("push_depth", depth, 3);
        check("push_flags", {ovf, unf}, 0);
        check("bram1", bram[1], 32'hA);
        check("bram2", bram[2], 32'hB);
        check("bram3", bram[3], 32'hC);

        // POP three times, then underflow.
        core_cycle(POP, 5'd0, 32'h0);
        check("pop1_raddr", g_raddr, 3); check("pop1_qv", r_qv, 1); check("pop1_q", r_q, 32'hC);
        core_cycle(POP, 5'd0, 32'h0);
        check("pop2_q", r_q, 32'hB);
        core_cycle(POP, 5'd0, 32'h0);
        check("pop3_q", r_q, 32'hA);
        check("pop3_depth", depth, 0);
        core_cycle(POP, 5'd0, 32'h0);
        check("pop4_gnt", g_gnt, 1);
        check("pop4_ren", g_ren, 0);
        check("pop4_qv", r_qv, 1);
        check("pop4_q", r_q, 32'h0);
        check("pop4_unf", unf, 1);
        check("pop4_rp", rp, 0);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
        check("unf_clr", unf, 0);
        @(posedge clk); #1;

        // Fill: push i writes 0x100+i to slot i+1 (mod 32).
        wr_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            core_cycle(PUSH, 5'd0, 32'h100 + i);
            if (g_gnt && g_wen) wr_cnt++;
        end
        check("fill_writes", wr_cnt, 32);
        check("fill_depth", depth, 32);
        check("fill_rp", rp, 0);
        check("fill_ovf", ovf, 0);
        check("bram0", bram[0], 32'h11F);
        core_cycle(PUSH, 5'd0, 32'hBAD);
        check("push33_gnt", g_gnt, 1);
        check("push33_wen", g_wen, 0);
        check("push33_ovf", ovf, 1);
        check("push33_depth", depth, 32);
        check("bram1_kept", bram[1], 32'h100);

        // err_clr in the same cycle as a new overflow: set wins; then a lone clear.
        err_clr = 1'b1; core_req = 1'b1; core_op = PUSH; core_d = 32'hBAD;
        @(posedge clk); #1;
        err_clr = 1'b0; core_req = 1'b0;
        @(negedge clk);
        check("ovf_set_wins", ovf, 1);
        @(posedge clk); #1;
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
        check("ovf_clr", ovf, 0);
        @(posedge clk); #1;

        // Debug write/read leave pointer state alone.
        dbg_cycle(1'b1, 5'd4, 32'h44);
        check("dbgw_gnt", d_gnt, 1);
        check("dbgw_rp", rp, 0);
        check("dbgw_depth", depth, 32);
        dbg_cycle(1'b0, 5'd4, 32'h0);
        check("dbgr_qv", d_qv, 1);
        check("dbgr_q", d_q, 32'h44);

        // Starvation: core PEEKs every cycle, debug reads slot 2.
        core_req = 1'b1; core_op = PEEK; core_ofs = 5'd0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd2;
        gcyc = 0; core_miss = 0; cg_at = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (gcyc == 0) begin
                if (dbg_gnt) begin
                    gcyc = i;
                    cg_at = core_gnt;
                end else if (!core_gnt) begin
                    core_miss++;
                end
            end
            @(posedge clk); #1;
            if (gcyc != 0) break;
        end
        core_req = 1'b0; dbg_req = 1'b0;
        check("starve_cycle", gcyc, 8);
        check("starve_core_gnt", cg_at, 0);
        check("starve_core_before", core_miss, 0);
        @(negedge clk);
        check("starve_dbg_qv", dbg_qv, 1);
        check("starve_dbg_q", dbg_q, 32'h101);
        check("starve_core_qv", core_qv, 0);
        @(posedge clk); #1;

        // Flush: no grant, pointers cleared.
        flush = 1'b1; core_req = 1'b1; core_op = PUSH; core_d = 32'h7;
        @(negedge clk);
        check("flush_gnt", core_gnt, 0);
        check("flush_wen", mem_wen, 0);
        @(posedge clk); #1;
        flush = 1'b0; core_req = 1'b0;
        @(negedge clk);
        check("flush_rp", rp, 0);
        check("flush_depth", depth, 0);
        @(posedge clk); #1;

        // PUSH 5, MOVE 9, PEEK 0 -> 9; PEEK 2 wraps to slot 31.
        core_cycle(PUSH, 5'd0, 32'h5);
        core_cycle(MOVE, 5'd0, 32'h9);
        check("move_waddr", g_waddr, 1);
        check("move_rp", rp, 1);
        core_cycle(PEEK, 5'd0, 32'h0);
        check("peek0_q", r_q, 32'h9);
        core_cycle(PEEK, 5'd2, 32'h0);
        check("peek2_raddr", g_raddr, 31);
        check("peek2_q", r_q, 32'h11E);
        check("peek_depth", depth, 1);

        // Flush right after a PEEK grant: the pending result is still delivered.
        core_req = 1'b1; core_op = PEEK; core_ofs = 5'd0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("flushpend_qv", core_qv, 1);
        check("flushpend_q", core_q, 32'h9);
        check("flushpend_gnt", core_gnt, 0);
        @(posedge clk); #1;
        flush = 1'b0; core_req = 1'b0;
        @(negedge clk);
        check("flushpend_rp", rp, 0);
        check("flushpend_qv_after", core_qv, 0);
        @(posedge clk); #1;

        // Async reset right after a POP grant: pending pulse dropped.
        core_cycle(PUSH, 5'd0, 32'h77);
        core_req = 1'b1; core_op = POP;
        @(negedge clk);
        check("rstpop_gnt", core_gnt, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstpop_qv", core_qv, 0);
        check("rstpop_gnt_low", core_gnt, 0);
        check("rstpop_ren", mem_ren, 0);
        check("rstpop_rp", rp, 0);
        check("rstpop_depth", depth, 0);
        @(posedge clk); #1;
        core_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstrel_qv", core_qv, 0);
        check("rstrel_rp", rp, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
